// File: rtl/cpu_seq_controller.sv
// cpu_seq_controller
//   Multi-phase control FSM for the 16-bit CPU datapath. Latches the 7-bit
//   opcode on imem_ack and sequences FETCH -> DECODE -> EXEC -> [MEM -> [WB]]
//   -> PCUPD, driving every datapath control input. Instruction and data
//   memory use req/ack handshakes guarded by a timeout watchdog.
//
//   Parameters
//     RST_HOLD  cycles PCrst stays high after rst falls (1..15)
//     TIMEOUT   max req cycles without ack before FAULT (2..255)
//
//   Ports
//     clk, rst             rising-edge clock, synchronous active-high reset
//     run_i                1 = execute; only looked at in FETCH
//     IW2Contr_i[6:0]      opcode IW[31:25]
//     imem_ack_i           instruction word valid
//     dmem_ack_i           data access complete
//     imem_req_o           fetch request, held until imem_ack
//     dmem_req_o           data request, held until dmem_ack
//     dmem_we_o            1 = STORE
//     LPC_o                PC load strobe / datapath phase clock
//     rd1_o, rd2_o         register-bank read enables
//     wr_contr_o           register write enable
//     Lflag_contr_o        flag latch enable
//     isJumpInstr_o        conditional jump in PCUPD
//     isCallInstr_o        unconditional PC <- z in PCUPD
//     PCrst_o              PC register reset
//     selM1_o..selM3_o     datapath mux selects
//     fnSel_o              ALU function select
//     halted_o, fault_o    sticky terminal-state flags
//
//   Every output is a flop loaded from the next-state decode, so outputs
//   change exactly with the state and are glitch-free.
module cpu_seq_controller #(
  parameter int RST_HOLD = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_i,
  input  logic [6:0] IW2Contr_i,
  input  logic       imem_ack_i,
  input  logic       dmem_ack_i,
  output logic       imem_req_o,
  output logic       dmem_req_o,
  output logic       dmem_we_o,
  output logic       LPC_o,
  output logic       rd1_o,
  output logic       rd2_o,
  output logic       wr_contr_o,
  output logic       Lflag_contr_o,
  output logic       isJumpInstr_o,
  output logic       isCallInstr_o,
  output logic       PCrst_o,
  output logic [1:0] selM1_o,
  output logic [1:0] selM2_o,
  output logic [1:0] selM3_o,
  output logic [1:0] fnSel_o,
  output logic       halted_o,
  output logic       fault_o
);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PCUPD, S_HALT, S_FAULT
  } state_e;

  typedef enum logic [3:0] {
    C_ALU, C_NOP, C_LOAD, C_STORE, C_CMP, C_HALT, C_JUMP, C_CALL, C_ILL
  } cls_e;

  localparam logic [3:0] HOLD_INIT = 4'(RST_HOLD);
  localparam logic [7:0] WD_LAST   = 8'(TIMEOUT - 1);

  function automatic cls_e decode(input logic [6:0] op);
    cls_e c;
    c = C_ILL;
    if (op[6]) c = C_ALU;
    else begin
      case (op[5:4])
        2'b00: begin
          case (op[3:0])
            4'h0:    c = C_NOP;
            4'h1:    c = C_LOAD;
            4'h2:    c = C_STORE;
            4'h3:    c = C_CMP;
            4'hF:    c = C_HALT;
            default: c = C_ILL;
          endcase
        end
        2'b01:   c = C_JUMP;
        2'b10:   c = C_CALL;
        default: c = C_ILL;
      endcase
    end
    return c;
  endfunction

  state_e     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic [7:0] wd_q, wd_d;
  logic [6:0] op_q, op_d;
  cls_e       cls;

  logic       imem_req_q, imem_req_d;
  logic       dmem_req_q, dmem_req_d;
  logic       dmem_we_q, dmem_we_d;
  logic       lpc_q, lpc_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic       lflag_q, lflag_d;
  logic       jmp_q, jmp_d;
  logic       call_q, call_d;
  logic       pcrst_q, pcrst_d;
  logic [1:0] m1_q, m1_d, m2_q, m2_d, m3_q, m3_d, fn_q, fn_d;
  logic       halted_q, halted_d;
  logic       fault_q, fault_d;

  // Next state. Acks only count while the matching request is actually out.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    wd_d    = wd_q;
    op_d    = op_q;
    case (state_q)
      S_RST: begin
        if (hold_q <= 4'd1) begin
          hold_d  = 4'd0;
          state_d = S_FETCH;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      S_FETCH: begin
        if (imem_req_q && imem_ack_i) begin
          op_d    = IW2Contr_i;
          state_d = S_DECODE;
        end else if (imem_req_q) begin
          if (wd_q == WD_LAST) state_d = S_FAULT;
          else                 wd_d    = wd_q + 8'd1;
        end
      end
      S_DECODE: begin
        case (decode(op_q))
          C_ILL:   state_d = S_FAULT;
          C_HALT:  state_d = S_HALT;
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        if (decode(op_q) inside {C_LOAD, C_STORE}) state_d = S_MEM;
        else                                       state_d = S_PCUPD;
      end
      S_MEM: begin
        if (dmem_req_q && dmem_ack_i) begin
          state_d = (decode(op_q) == C_LOAD) ? S_WB : S_PCUPD;
        end else if (dmem_req_q) begin
          if (wd_q == WD_LAST) state_d = S_FAULT;
          else                 wd_d    = wd_q + 8'd1;
        end
      end
      S_WB:    state_d = S_PCUPD;
      S_PCUPD: state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
    // Watchdog restarts for each new handshake.
    if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state_q) wd_d = 8'd0;
  end

  assign cls = decode(op_d);

  // Output decode of the next state, registered below.
  always_comb begin
    imem_req_d = 1'b0;
    dmem_req_d = 1'b0;
    dmem_we_d  = 1'b0;
    lpc_d      = 1'b0;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    lflag_d    = 1'b0;
    jmp_d      = 1'b0;
    call_d     = 1'b0;
    pcrst_d    = 1'b0;
    m1_d       = 2'b00;
    m2_d       = 2'b00;
    m3_d       = 2'b00;
    fn_d       = 2'b00;
    halted_d   = 1'b0;
    fault_d    = 1'b0;

    // Selects are set up in EXEC and held to the end of the instruction so
    // address and branch target stay stable through MEM/WB/PCUPD.
    if (state_d inside {S_EXEC, S_MEM, S_WB, S_PCUPD}) begin
      rd_d = 1'b1;
      case (cls)
        C_ALU: begin
          m1_d = op_d[2] ? 2'b10 : 2'b01;
          m3_d = 2'b10;
        end
        C_CMP: m1_d = 2'b01;
        C_LOAD, C_STORE: begin
          m1_d = 2'b10;
          fn_d = 2'b01;
        end
        C_JUMP, C_CALL: begin
          m2_d = 2'b10;
          fn_d = 2'b10;
        end
        default: ;
      endcase
    end

    case (state_d)
      S_RST:    pcrst_d = 1'b1;
      // Once raised, the fetch request stays up until acked even if run drops.
      S_FETCH:  imem_req_d = run_i || (state_q == S_FETCH && imem_req_q);
      S_DECODE: rd_d = 1'b1;
      S_EXEC: begin
        wr_d    = (cls == C_ALU) || (cls == C_CALL);
        lflag_d = (cls == C_CMP);
      end
      S_MEM: begin
        dmem_req_d = 1'b1;
        dmem_we_d  = (cls == C_STORE);
      end
      S_WB: begin
        m3_d = 2'b01;
        wr_d = 1'b1;
      end
      S_PCUPD: begin
        lpc_d  = 1'b1;
        jmp_d  = (cls == C_JUMP);
        call_d = (cls == C_CALL);
      end
      S_HALT: begin
        halted_d = 1'b1;
        rd_d     = 1'b0;
      end
      S_FAULT: begin
        fault_d = 1'b1;
        rd_d    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RST;
      hold_q     <= HOLD_INIT;
      wd_q       <= 8'd0;
      op_q       <= 7'd0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      lpc_q      <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      lflag_q    <= 1'b0;
      jmp_q      <= 1'b0;
      call_q     <= 1'b0;
      pcrst_q    <= 1'b1;
      m1_q       <= 2'b00;
      m2_q       <= 2'b00;
      m3_q       <= 2'b00;
      fn_q       <= 2'b00;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      wd_q       <= wd_d;
      op_q       <= op_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      lpc_q      <= lpc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      lflag_q    <= lflag_d;
      jmp_q      <= jmp_d;
      call_q     <= call_d;
      pcrst_q    <= pcrst_d;
      m1_q       <= m1_d;
      m2_q       <= m2_d;
      m3_q       <= m3_d;
      fn_q       <= fn_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  assign imem_req_o    = imem_req_q;
  assign dmem_req_o    = dmem_req_q;
  assign dmem_we_o     = dmem_we_q;
  assign LPC_o         = lpc_q;
  assign rd1_o         = rd_q;
  assign rd2_o         = rd_q;
  assign wr_contr_o    = wr_q;
  assign Lflag_contr_o = lflag_q;
  assign isJumpInstr_o = jmp_q;
  assign isCallInstr_o = call_q;
  assign PCrst_o       = pcrst_q;
  assign selM1_o       = m1_q;
  assign selM2_o       = m2_q;
  assign selM3_o       = m3_q;
  assign fnSel_o       = fn_q;
  assign halted_o      = halted_q;
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_cpu_seq_controller.sv
module tb_cpu_seq_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b1;
  logic [6:0] iw = 7'd0;
  logic imem_ack = 1'b0, dmem_ack = 1'b0;
  logic imem_req, dmem_req, dmem_we, lpc, rd1, rd2, wr, lflag, isj, isc, pcrst, halted, fault;
  logic [1:0] m1, m2, m3, fn;
  int total = 0;
  int bad = 0;

  cpu_seq_controller #(.RST_HOLD(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .run_i(run), .IW2Contr_i(iw),
    .imem_ack_i(imem_ack), .dmem_ack_i(dmem_ack),
    .imem_req_o(imem_req), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
    .LPC_o(lpc), .rd1_o(rd1), .rd2_o(rd2), .wr_contr_o(wr),
    .Lflag_contr_o(lflag), .isJumpInstr_o(isj), .isCallInstr_o(isc),
    .PCrst_o(pcrst), .selM1_o(m1), .selM2_o(m2), .selM3_o(m3), .fnSel_o(fn),
    .halted_o(halted), .fault_o(fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert rst for n cycles; leaves the bench in the last RST hold cycle.
  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    repeat (3) tick();
  endtask

  // Currently in FETCH with request up: ack with opcode, land in DECODE.
  task automatic fetch_now(input logic [6:0] op, input string nm);
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL %s_req got=%b exp=1", nm, imem_req); end
    total++; if (lpc !== 1'b0 || pcrst !== 1'b0) begin bad++; $display("FAIL %s_fetch_strobes lpc=%b pcrst=%b exp=0,0", nm, lpc, pcrst); end
    iw = op; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    total++; if ({rd1, rd2, imem_req, wr} !== 4'b1100) begin bad++; $display("FAIL %s_decode rd1rd2reqwr got=%b exp=1100", nm, {rd1, rd2, imem_req, wr}); end
  endtask

  task automatic do_fetch(input logic [6:0] op, input string nm);
    tick();
    fetch_now(op, nm);
  endtask

  task automatic test_reset();
    tick();
    total++; if ({pcrst, imem_req, lpc, wr, halted, fault} !== 6'b100000) begin bad++; $display("FAIL reset_outputs got=%b exp=100000", {pcrst, imem_req, lpc, wr, halted, fault}); end
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (pcrst !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL reset_hold%0d pcrst=%b req=%b exp=1,0", i, pcrst, imem_req); end
      if (i < 3) tick();
    end
  endtask

  task automatic test_alu(input logic [6:0] op, input logic [1:0] exp_m1, input string nm);
    do_fetch(op, nm);
    tick();
    total++; if ({wr, lflag, lpc} !== 3'b100) begin bad++; $display("FAIL %s_exec_strobes got=%b exp=100", nm, {wr, lflag, lpc}); end
    total++; if ({m1, m2, m3, fn} !== {exp_m1, 2'b00, 2'b10, 2'b00}) begin bad++; $display("FAIL %s_exec_sel got=%b exp=%b", nm, {m1, m2, m3, fn}, {exp_m1, 6'b001000}); end
    tick();
    total++; if ({lpc, wr, isj, isc} !== 4'b1000) begin bad++; $display("FAIL %s_pcupd got=%b exp=1000", nm, {lpc, wr, isj, isc}); end
  endtask

  task automatic test_cmp();
    do_fetch(7'b0000011, "cmp");
    tick();
    total++; if ({lflag, wr, fn} !== 4'b1000) begin bad++; $display("FAIL cmp_exec lflag,wr,fn got=%b exp=1000", {lflag, wr, fn}); end
    tick();
    total++; if ({lpc, lflag, wr} !== 3'b100) begin bad++; $display("FAIL cmp_pcupd got=%b exp=100", {lpc, lflag, wr}); end
  endtask

  task automatic test_load();
    do_fetch(7'b0000001, "load");
    tick();
    total++; if ({fn, m1, m2, wr} !== 7'b0110000) begin bad++; $display("FAIL load_exec fn,m1,m2,wr got=%b exp=0110000", {fn, m1, m2, wr}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({dmem_req, dmem_we, lpc, wr} !== 4'b1000) begin bad++; $display("FAIL load_mem%0d got=%b exp=1000", i, {dmem_req, dmem_we, lpc, wr}); end
    end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    total++; if ({dmem_req, m3, wr, lpc} !== 5'b00110) begin bad++; $display("FAIL load_wb req,m3,wr,lpc got=%b exp=00110", {dmem_req, m3, wr, lpc}); end
    tick();
    total++; if ({lpc, wr} !== 2'b10) begin bad++; $display("FAIL load_pcupd got=%b exp=10", {lpc, wr}); end
  endtask

  task automatic test_store();
    do_fetch(7'b0000010, "store");
    tick();
    tick();
    total++; if ({dmem_req, dmem_we, fn, m1} !== 6'b110110) begin bad++; $display("FAIL store_mem req,we,fn,m1 got=%b exp=110110", {dmem_req, dmem_we, fn, m1}); end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    total++; if ({lpc, dmem_req, dmem_we, wr} !== 4'b1000) begin bad++; $display("FAIL store_pcupd got=%b exp=1000", {lpc, dmem_req, dmem_we, wr}); end
  endtask

  task automatic test_jump();
    do_fetch(7'b0010101, "jump");
    tick();
    total++; if ({m2, fn, lflag, wr} !== 6'b101000) begin bad++; $display("FAIL jump_exec got=%b exp=101000", {m2, fn, lflag, wr}); end
    tick();
    total++; if ({lpc, isj, isc, fn, m2} !== 7'b1101010) begin bad++; $display("FAIL jump_pcupd got=%b exp=1101010", {lpc, isj, isc, fn, m2}); end
  endtask

  task automatic test_call();
    do_fetch(7'b0100000, "call");
    tick();
    total++; if ({wr, m3, m2, fn} !== 7'b1001010) begin bad++; $display("FAIL call_exec got=%b exp=1001010", {wr, m3, m2, fn}); end
    tick();
    total++; if ({lpc, isc, isj, wr} !== 4'b1100) begin bad++; $display("FAIL call_pcupd got=%b exp=1100", {lpc, isc, isj, wr}); end
  endtask

  // run=0 idles FETCH; an ack with no request outstanding is ignored.
  task automatic test_run_idle();
    run = 1'b0;
    tick();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL idle_req got=%b exp=0", imem_req); end
    imem_ack = 1'b1; iw = 7'b1000000;
    tick();
    imem_ack = 1'b0;
    total++; if ({imem_req, rd1, fault} !== 3'b000) begin bad++; $display("FAIL idle_ack_ignored got=%b exp=000", {imem_req, rd1, fault}); end
    run = 1'b1;
    tick();
    fetch_now(7'b0000000, "nop");
    tick();
    total++; if ({wr, lflag, dmem_req} !== 3'b000) begin bad++; $display("FAIL nop_exec got=%b exp=000", {wr, lflag, dmem_req}); end
    tick();
    total++; if (lpc !== 1'b1) begin bad++; $display("FAIL nop_pcupd lpc got=%b exp=1", lpc); end
  endtask

  // Ack arriving in the 16th request cycle beats the watchdog.
  task automatic test_timeout_edge();
    tick();
    repeat (15) tick();
    fetch_now(7'b0000000, "wd_edge");
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL wd_edge_fault got=%b exp=0", fault); end
    tick(); tick();
  endtask

  task automatic test_illegal();
    do_fetch(7'b0000111, "ill");
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL ill_decode_fault got=%b exp=0", fault); end
    tick();
    total++; if ({fault, rd1, wr, lpc} !== 4'b1000) begin bad++; $display("FAIL ill_fault got=%b exp=1000", {fault, rd1, wr, lpc}); end
    do_reset(2);
  endtask

  task automatic test_mid_reset();
    do_fetch(7'b0000001, "mid");
    tick(); tick();
    total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL mid_mem_req got=%b exp=1", dmem_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if ({dmem_req, pcrst, imem_req} !== 3'b010) begin bad++; $display("FAIL mid_abort req,pcrst,ireq got=%b exp=010", {dmem_req, pcrst, imem_req}); end
    repeat (3) tick();
    total++; if (pcrst !== 1'b1) begin bad++; $display("FAIL mid_hold pcrst got=%b exp=1", pcrst); end
  endtask

  task automatic test_timeout();
    tick();
    for (int i = 0; i < 16; i++) begin
      total++; if ({imem_req, fault} !== 2'b10) begin bad++; $display("FAIL wd_cycle%0d req,fault got=%b exp=10", i, {imem_req, fault}); end
      tick();
    end
    total++; if ({fault, imem_req} !== 2'b10) begin bad++; $display("FAIL wd_fault got=%b exp=10", {fault, imem_req}); end
    imem_ack = 1'b1;
    repeat (3) tick();
    imem_ack = 1'b0;
    total++; if ({fault, imem_req, rd1} !== 3'b100) begin bad++; $display("FAIL wd_sticky got=%b exp=100", {fault, imem_req, rd1}); end
    do_reset(1);
  endtask

  task automatic test_halt();
    do_fetch(7'b0001111, "halt");
    tick();
    total++; if ({halted, fault, rd1} !== 3'b100) begin bad++; $display("FAIL halt_enter got=%b exp=100", {halted, fault, rd1}); end
    imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (4) tick();
    imem_ack = 1'b0; dmem_ack = 1'b0;
    total++; if ({halted, imem_req, dmem_req, lpc, wr} !== 5'b10000) begin bad++; $display("FAIL halt_sticky got=%b exp=10000", {halted, imem_req, dmem_req, lpc, wr}); end
  endtask

  initial begin
    test_reset();
    test_alu(7'b1000100, 2'b10, "alu_imm");
    test_alu(7'b1010000, 2'b01, "alu_rr");
    test_cmp();
    test_load();
    test_store();
    test_jump();
    test_call();
    test_run_idle();
    test_timeout_edge();
    test_illegal();
    test_mid_reset();
    test_timeout();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
